// File: rtl/cpu_machine_controller.sv
// Eight-state instruction sequencer for the accumulator CPU.
// It decodes the opcode into registered fetch, execute and halt strobes.
module cpu_machine_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       datactl_ena,
  output logic       halt
);

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } state_t;

  state_t state, state_nxt;

  logic inc_pc_nxt, load_pc_nxt, load_acc_nxt, rd_nxt, wr_nxt;
  logic load_ir_nxt, datactl_ena_nxt, halt_nxt;
  logic alu_op, skz_taken;

  assign alu_op    = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                     (opcode == OP_XORR) || (opcode == OP_LDA);
  assign skz_taken = (opcode == OP_SKZ) && zero;

  always_comb begin
    state_nxt       = S0;
    inc_pc_nxt      = 1'b0;
    load_pc_nxt     = 1'b0;
    load_acc_nxt    = 1'b0;
    rd_nxt          = 1'b0;
    wr_nxt          = 1'b0;
    load_ir_nxt     = 1'b0;
    datactl_ena_nxt = 1'b0;
    halt_nxt        = 1'b0;
    // ena low parks the sequencer in S0 with every strobe cleared
    if (ena) begin
      case (state)
        S0: begin
          load_ir_nxt = 1'b1;
          rd_nxt      = 1'b1;
          inc_pc_nxt  = 1'b1;
          state_nxt   = S1;
        end
        S1: begin
          load_ir_nxt = 1'b1;
          rd_nxt      = 1'b1;
          inc_pc_nxt  = 1'b1;
          state_nxt   = S2;
        end
        S2: state_nxt = S3;
        S3: begin
          if (opcode == OP_HLT) begin
            inc_pc_nxt = 1'b1;
            halt_nxt   = 1'b1;
            state_nxt  = S3;
          end else begin
            state_nxt  = S4;
          end
        end
        S4: begin
          if (opcode == OP_JMP) begin
            load_pc_nxt = 1'b1;
            inc_pc_nxt  = 1'b1;
          end else if (alu_op) begin
            rd_nxt = 1'b1;
          end else if (opcode == OP_STO) begin
            datactl_ena_nxt = 1'b1;
          end
          state_nxt = S5;
        end
        S5: begin
          if (alu_op) begin
            rd_nxt       = 1'b1;
            load_acc_nxt = 1'b1;
          end else if (skz_taken) begin
            inc_pc_nxt = 1'b1;
          end else if (opcode == OP_JMP) begin
            load_pc_nxt = 1'b1;
            inc_pc_nxt  = 1'b1;
          end else if (opcode == OP_STO) begin
            wr_nxt          = 1'b1;
            datactl_ena_nxt = 1'b1;
          end
          state_nxt = S6;
        end
        S6: begin
          if (alu_op) begin
            rd_nxt = 1'b1;
          end else if (opcode == OP_STO) begin
            datactl_ena_nxt = 1'b1;
          end
          state_nxt = S7;
        end
        S7: begin
          inc_pc_nxt = skz_taken;
          state_nxt  = S0;
        end
        default: state_nxt = S0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S0;
      inc_pc      <= 1'b0;
      load_pc     <= 1'b0;
      load_acc    <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      load_ir     <= 1'b0;
      datactl_ena <= 1'b0;
      halt        <= 1'b0;
    end else begin
      state       <= state_nxt;
      inc_pc      <= inc_pc_nxt;
      load_pc     <= load_pc_nxt;
      load_acc    <= load_acc_nxt;
      rd          <= rd_nxt;
      wr          <= wr_nxt;
      load_ir     <= load_ir_nxt;
      datactl_ena <= datactl_ena_nxt;
      halt        <= halt_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_machine_controller.sv
// Bench for cpu_machine_controller: directed vector table, reset corner cases,
// and randomized traffic against a per-signal rule model.
module tb_cpu_machine_controller;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDD = 3'd3;
  localparam logic [2:0] XORR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  // output byte: {inc_pc, load_pc, load_acc, rd, wr, load_ir, datactl_ena, halt}
  localparam logic [7:0] F  = 8'h94;
  localparam logic [7:0] Z  = 8'h00;
  localparam logic [7:0] R  = 8'h10;
  localparam logic [7:0] RA = 8'h30;
  localparam logic [7:0] J  = 8'hC0;
  localparam logic [7:0] I  = 8'h80;
  localparam logic [7:0] D  = 8'h02;
  localparam logic [7:0] WD = 8'h0A;
  localparam logic [7:0] H  = 8'h81;

  logic clk = 1'b0;
  logic rst, ena, zero;
  logic [2:0] opcode;
  logic inc_pc, load_pc, load_acc, rd, wr, load_ir, datactl_ena, halt;
  logic [7:0] outs;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       ena;
    logic [2:0] op;
    logic       z;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  cpu_machine_controller dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
    .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc), .rd(rd), .wr(wr),
    .load_ir(load_ir), .datactl_ena(datactl_ena), .halt(halt)
  );

  assign outs = {inc_pc, load_pc, load_acc, rd, wr, load_ir, datactl_ena, halt};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic vec(input logic e, input logic [2:0] op, input logic z, input logic [7:0] x);
    tbl.push_back('{ena: e, op: op, z: z, exp: x});
  endtask

  // eight enabled edges of one instruction, first expected byte in the MSBs
  task automatic instr(input logic [2:0] op, input logic z, input logic [63:0] xs);
    for (int k = 0; k < 8; k++) vec(1'b1, op, z, xs[63-8*k -: 8]);
  endtask

  // Behavioural reference: each strobe as a rule over the cycle-in-instruction.
  function automatic logic [7:0] model_out(input int ph, input logic [2:0] op, input logic z);
    logic fetch, alu, sto, jmp, skz_t, hlt, mid;
    fetch = (ph < 2);
    alu   = (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
    sto   = (op == STO);
    jmp   = (op == JMP);
    skz_t = (op == SKZ) && z;
    hlt   = (op == HLT);
    mid   = (ph >= 4) && (ph <= 6);
    return {
      fetch || (ph == 3 && hlt) || (jmp && (ph == 4 || ph == 5)) || (skz_t && (ph == 5 || ph == 7)),
      jmp && (ph == 4 || ph == 5),
      alu && ph == 5,
      fetch || (alu && mid),
      sto && ph == 5,
      fetch,
      sto && mid,
      hlt && ph == 3
    };
  endfunction

  initial begin
    rst = 1'b1; ena = 1'b0; opcode = ADD; zero = 1'b0;

    // directed table built from the hand-derived edge-by-edge behaviour
    instr(ADD, 1'b0, {F, F, Z, Z, R, RA, R, Z});
    instr(SKZ, 1'b1, {F, F, Z, Z, Z, I, Z, I});
    instr(SKZ, 1'b0, {F, F, Z, Z, Z, Z, Z, Z});
    instr(STO, 1'b1, {F, F, Z, Z, D, WD, D, Z});
    instr(JMP, 1'b0, {F, F, Z, Z, J, J, Z, Z});
    instr(LDA, 1'b1, {F, F, Z, Z, R, RA, R, Z});
    instr(HLT, 1'b0, {F, F, Z, H, H, H, H, H});
    vec(1'b1, HLT, 1'b1, H);
    vec(1'b0, HLT, 1'b0, Z);
    instr(XORR, 1'b0, {F, F, Z, Z, R, RA, R, Z});
    vec(1'b1, ANDD, 1'b0, F);
    vec(1'b1, ANDD, 1'b0, F);
    vec(1'b1, ANDD, 1'b0, Z);
    vec(1'b1, ANDD, 1'b0, Z);
    vec(1'b0, ANDD, 1'b0, Z);
    vec(1'b1, ANDD, 1'b0, F);

    #1 rst = 1'b0;
    #1 check("reset_async", outs, Z);
    ena = 1'b1;
    @(posedge clk); #1 check("reset_priority", outs, Z);
    @(posedge clk); #1 check("reset_hold", outs, Z);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      ena = tbl[i].ena; opcode = tbl[i].op; zero = tbl[i].z;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), outs, tbl[i].exp);
    end

    // asynchronous reset in S5 of an ADD, then restart from S0
    ena = 1'b0;
    @(posedge clk); #1;
    ena = 1'b1; opcode = ADD; zero = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
    end
    check("add_s5", outs, RA);
    #2 rst = 1'b0;
    #1 check("midinstr_reset", outs, Z);
    #1 rst = 1'b1;
    @(posedge clk); #1 check("post_reset_fetch", outs, F);
    @(posedge clk); #1 check("post_reset_fetch2", outs, F);

    // randomized traffic against the reference model
    begin
      int ph;
      logic [7:0] exp;
      rst = 1'b0; #1; rst = 1'b1;
      ph = 0;
      for (int n = 0; n < 3000; n++) begin
        ena    = ($urandom_range(0, 19) != 0);
        opcode = 3'($urandom_range(0, 7));
        zero   = 1'($urandom_range(0, 1));
        @(posedge clk);
        if (!ena) begin
          exp = Z;
          ph  = 0;
        end else begin
          exp = model_out(ph, opcode, zero);
          ph  = (ph == 3 && opcode == HLT) ? 3 : (ph + 1) % 8;
        end
        #1;
        check($sformatf("rand%0d", n), outs, exp);
        check("rd_wr_exclusive", {7'd0, rd & wr}, 8'd0);
        if ($urandom_range(0, 49) == 0) begin
          rst = 1'b0;
          #1 check("rand_async_reset", outs, Z);
          ph = 0;
          rst = 1'b1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_machine_controller.md
CPU_MACHINE_CONTROLLER -- requirements
Module: cpu_machine_controller

Interface
REQ-001 The block SHALL have no parameters; opcode encoding is fixed by REQ-014.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state and output registers.
REQ-004 rst  input  1  asynchronous active-low reset; 0 forces the reset state immediately.
REQ-005 ena  input  1  run enable; 1 advances the FSM, 0 parks it.
REQ-006 opcode  input  3  bits [15:13] of the instruction register output.
REQ-007 zero  input  1  accumulator-equals-zero flag from the ALU.
REQ-008 inc_pc  output  1  program counter increment strobe.
REQ-009 load_pc  output  1  program counter load from the instruction register address field.
REQ-010 load_acc  output  1  accumulator load from the ALU.
REQ-011 rd, wr  output  1 each  memory read and write strobes.
REQ-012 load_ir  output  1  instruction register byte-load enable; this drives the instruction register's enable input.
REQ-013 datactl_ena  output  1  accumulator-to-data-bus driver enable; halt  output  1  CPU halted flag.

Function
REQ-014 Opcodes SHALL be encoded as HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111.
- The ALU group is ADD, ANDD, XORR, LDA.
REQ-015 The FSM SHALL have eight states, S0 to S7, encoded 3 bits.
- Every output SHALL be registered.
- On each rising clk edge with ena=1, the outputs SHALL take the values listed for the current state, and the state SHALL advance.
REQ-016 S0 and S1 SHALL output load_ir=1, rd=1, inc_pc=1 (high and low byte fetch) and SHALL advance to the next state.
REQ-017 S2 SHALL output all zeros and advance to S3.
REQ-018 S3 behaviour SHALL depend on opcode:
- HLT: inc_pc=1, halt=1; remain in S3.
- Any other opcode: all outputs 0; advance to S4.
REQ-019 S4 outputs SHALL be:
- JMP: load_pc=1, inc_pc=1.
- ALU group: rd=1.
- STO: datactl_ena=1.
- Otherwise: 0.
- Next state is S5.
REQ-020 S5 outputs SHALL be:
- ALU group: rd=1, load_acc=1.
- SKZ with zero=1: inc_pc=1.
- JMP: load_pc=1, inc_pc=1.
- STO: wr=1, datactl_ena=1.
- Otherwise: 0.
- Next state is S6.
REQ-021 S6 outputs SHALL be:
- ALU group: rd=1.
- STO: datactl_ena=1.
- Otherwise: 0.
- Next state is S7.
REQ-022 S7 outputs SHALL be inc_pc=1 for SKZ with zero=1, otherwise 0; next state is S0.
- An instruction therefore takes exactly 8 enabled cycles.
REQ-023 opcode and zero SHALL be sampled only in S3 to S7; they are don't-care in S0 to S2.
REQ-024 Outputs not named for a state/opcode combination SHALL be 0.
- rd and wr SHALL never both be 1.
REQ-025 When ena=0 at a rising edge, the next state SHALL be S0 and all outputs SHALL be 0, including from S3 halted and mid-instruction.
REQ-026 Once halted, halt SHALL remain 1 until rst=0 or ena=0, with no further fetch.

Reset
REQ-027 With rst=0, state SHALL be S0 and all outputs 0 asynchronously, with no wait for clk.
REQ-028 Reset SHALL take priority over ena and all other inputs, including reset asserted mid-instruction.
REQ-029 After rst releases, the first enabled edge SHALL execute S0.

Verification
REQ-030 Reset release, ena=1, opcode=ADD: edges 1 and 2 give load_ir=rd=inc_pc=1; edge 5 gives rd=1; edge 6 gives rd=load_acc=1; edge 7 gives rd=1; edge 9 repeats the fetch.
REQ-031 opcode=SKZ: with zero=1, inc_pc=1 at edges 6 and 8; repeated with zero=0, inc_pc is 0 at edges 3 to 8.
REQ-032 opcode=STO: datactl_ena=1 at edges 5 to 7; wr=1 only at edge 6; rd=0 at edges 3 to 8. opcode=JMP: load_pc=inc_pc=1 at edges 5 and 6.
REQ-033 opcode=HLT: from edge 4 onward, halt=inc_pc=1 indefinitely. Dropping ena gives all outputs 0 at the next edge; re-raising ena restarts the fetch from S0.
REQ-034 rst=0 pulsed asynchronously during S5 of an ADD: all outputs 0 before the next clk edge; after release, the first enabled edge produces S0 outputs.
